// File: rtl/id_stage_p_if.sv
// id_stage_p_if: decode-stage bus between IF/ID, regfile,
// forwarding network, pipeline controller and the ID/EX outputs.
interface id_stage_p_if #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 2,
    parameter int CNT_W  = 16
);
    logic [31:0]             pc_i;
    logic [31:0]             inst_i;
    logic                    inst_vld_i;
    logic [DATA_W-1:0]       reg1_data_i;
    logic [DATA_W-1:0]       reg2_data_i;
    logic [FWD_N-1:0]        fwd_wreg_i;
    logic [5*FWD_N-1:0]      fwd_wd_i;
    logic [DATA_W*FWD_N-1:0] fwd_wdata_i;
    logic                    ex_is_load_i;
    logic                    hold_i;
    logic                    flush_i;
    logic                    reg1_read_o;
    logic                    reg2_read_o;
    logic [4:0]              reg1_addr_o;
    logic [4:0]              reg2_addr_o;
    logic                    stall_req_o;
    logic [31:0]             ex_pc_o;
    logic [7:0]              ex_aluop_o;
    logic [2:0]              ex_alusel_o;
    logic [DATA_W-1:0]       ex_reg1_o;
    logic [DATA_W-1:0]       ex_reg2_o;
    logic [4:0]              ex_wd_o;
    logic                    ex_wreg_o;
    logic                    ex_is_load_o;
    logic [CNT_W-1:0]        inv_cnt_o;

    modport master (
        input  pc_i, inst_i, inst_vld_i, reg1_data_i, reg2_data_i,
        input  fwd_wreg_i, fwd_wd_i, fwd_wdata_i, ex_is_load_i,
        input  hold_i, flush_i,
        output reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o,
        output stall_req_o, ex_pc_o, ex_aluop_o, ex_alusel_o,
        output ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
        output ex_is_load_o, inv_cnt_o
    );

    modport slave (
        output pc_i, inst_i, inst_vld_i, reg1_data_i, reg2_data_i,
        output fwd_wreg_i, fwd_wd_i, fwd_wdata_i, ex_is_load_i,
        output hold_i, flush_i,
        input  reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o,
        input  stall_req_o, ex_pc_o, ex_aluop_o, ex_alusel_o,
        input  ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
        input  ex_is_load_o, inv_cnt_o
    );
endinterface

// File: rtl/id_stage_p.sv
// id_stage_p: MIPS32 decode stage with operand forwarding,
// load-use bubble insertion and the ID/EX pipeline register.
module id_stage_p #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 2,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          rst,
    id_stage_p_if.master bus
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LW      = 6'h23;

    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SYNC = 6'h0F;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_LOAD  = 3'b111;

    typedef struct packed {
        logic [31:0]       pc;
        logic [7:0]        aluop;
        logic [2:0]        alusel;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [4:0]        wd;
        logic              wreg;
        logic              is_load;
    } id_ex_t;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;

    assign op    = bus.inst_i[31:26];
    assign rs    = bus.inst_i[25:21];
    assign rt    = bus.inst_i[20:16];
    assign rd    = bus.inst_i[15:11];
    assign sa    = bus.inst_i[10:6];
    assign funct = bus.inst_i[5:0];
    assign imm16 = bus.inst_i[15:0];

    logic [7:0]        d_aluop;
    logic [2:0]        d_alusel;
    logic [4:0]        d_wd;
    logic              d_wreg;
    logic              d_load;
    logic              re1;
    logic              re2;
    logic [DATA_W-1:0] imm;
    logic              inv;
    logic              f_rr;
    logic              f_sh;
    logic              f_im;

    // Decode opcode/funct into ALU controls, read enables and immediate
    always_comb begin
        d_aluop  = 8'h00;
        d_alusel = 3'b000;
        d_wd     = 5'd0;
        d_wreg   = 1'b0;
        d_load   = 1'b0;
        re1      = 1'b0;
        re2      = 1'b0;
        imm      = '0;
        inv      = 1'b0;
        f_rr     = 1'b0;
        f_sh     = 1'b0;
        f_im     = 1'b0;
        if (bus.inst_vld_i) begin
            unique case (1'b1)
                op == OP_SPECIAL: begin
                    unique case (1'b1)
                        sa == 5'd0 && funct == F_OR: begin
                            d_aluop = 8'h25; d_alusel = SEL_LOGIC; f_rr = 1'b1;
                        end
                        sa == 5'd0 && funct == F_AND: begin
                            d_aluop = 8'h24; d_alusel = SEL_LOGIC; f_rr = 1'b1;
                        end
                        sa == 5'd0 && funct == F_XOR: begin
                            d_aluop = 8'h26; d_alusel = SEL_LOGIC; f_rr = 1'b1;
                        end
                        sa == 5'd0 && funct == F_NOR: begin
                            d_aluop = 8'h27; d_alusel = SEL_LOGIC; f_rr = 1'b1;
                        end
                        sa == 5'd0 && funct == F_SLLV: begin
                            d_aluop = 8'h7C; d_alusel = SEL_SHIFT; f_rr = 1'b1;
                        end
                        sa == 5'd0 && funct == F_SRLV: begin
                            d_aluop = 8'h02; d_alusel = SEL_SHIFT; f_rr = 1'b1;
                        end
                        sa == 5'd0 && funct == F_SRAV: begin
                            d_aluop = 8'h03; d_alusel = SEL_SHIFT; f_rr = 1'b1;
                        end
                        sa == 5'd0 && funct == F_ADD: begin
                            d_aluop = 8'h20; d_alusel = SEL_ARITH; f_rr = 1'b1;
                        end
                        sa == 5'd0 && funct == F_ADDU: begin
                            d_aluop = 8'h21; d_alusel = SEL_ARITH; f_rr = 1'b1;
                        end
                        sa == 5'd0 && funct == F_SUB: begin
                            d_aluop = 8'h22; d_alusel = SEL_ARITH; f_rr = 1'b1;
                        end
                        rs == 5'd0 && funct == F_SLL: begin
                            d_aluop = 8'h7C; d_alusel = SEL_SHIFT; f_sh = 1'b1;
                        end
                        rs == 5'd0 && funct == F_SRL: begin
                            d_aluop = 8'h02; d_alusel = SEL_SHIFT; f_sh = 1'b1;
                        end
                        rs == 5'd0 && funct == F_SRA: begin
                            d_aluop = 8'h03; d_alusel = SEL_SHIFT; f_sh = 1'b1;
                        end
                        funct == F_SYNC: begin
                            d_aluop = 8'h00;
                        end
                        default: inv = 1'b1;
                    endcase
                end
                op == OP_ORI: begin
                    d_aluop = 8'h25; d_alusel = SEL_LOGIC; f_im = 1'b1;
                    imm = DATA_W'(imm16);
                end
                op == OP_ANDI: begin
                    d_aluop = 8'h24; d_alusel = SEL_LOGIC; f_im = 1'b1;
                    imm = DATA_W'(imm16);
                end
                op == OP_XORI: begin
                    d_aluop = 8'h26; d_alusel = SEL_LOGIC; f_im = 1'b1;
                    imm = DATA_W'(imm16);
                end
                op == OP_LUI: begin
                    d_aluop = 8'h25; d_alusel = SEL_LOGIC; f_im = 1'b1;
                    imm = DATA_W'({imm16, 16'h0000});
                end
                op == OP_ADDI: begin
                    d_aluop = 8'h20; d_alusel = SEL_ARITH; f_im = 1'b1;
                    imm = DATA_W'($signed(imm16));
                end
                op == OP_ADDIU: begin
                    d_aluop = 8'h21; d_alusel = SEL_ARITH; f_im = 1'b1;
                    imm = DATA_W'($signed(imm16));
                end
                op == OP_LW: begin
                    d_aluop = 8'hE3; d_alusel = SEL_LOAD; f_im = 1'b1;
                    d_load = 1'b1;
                    imm = DATA_W'($signed(imm16));
                end
                default: inv = 1'b1;
            endcase
        end
        if (f_rr) begin
            re1 = 1'b1; re2 = 1'b1; d_wd = rd; d_wreg = 1'b1;
        end
        if (f_sh) begin
            re2 = 1'b1; imm = DATA_W'(sa); d_wd = rd; d_wreg = 1'b1;
        end
        if (f_im) begin
            re1 = 1'b1; d_wd = rt; d_wreg = 1'b1;
        end
    end

    assign bus.reg1_read_o = re1;
    assign bus.reg2_read_o = re2;
    assign bus.reg1_addr_o = rs;
    assign bus.reg2_addr_o = rt;

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    // Resolve operands: $0, then youngest matching forward, then regfile
    always_comb begin
        op1 = imm;
        op2 = imm;
        if (re1) begin
            op1 = bus.reg1_data_i;
            for (int k = FWD_N - 1; k >= 0; k--) begin
                if (bus.fwd_wreg_i[k] && bus.fwd_wd_i[5*k +: 5] == rs)
                    op1 = bus.fwd_wdata_i[DATA_W*k +: DATA_W];
            end
            if (rs == 5'd0)
                op1 = '0;
        end
        if (re2) begin
            op2 = bus.reg2_data_i;
            for (int k = FWD_N - 1; k >= 0; k--) begin
                if (bus.fwd_wreg_i[k] && bus.fwd_wd_i[5*k +: 5] == rt)
                    op2 = bus.fwd_wdata_i[DATA_W*k +: DATA_W];
            end
            if (rt == 5'd0)
                op2 = '0;
        end
    end

    id_ex_t           dec;
    id_ex_t           ex_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stall;

    assign dec.pc      = bus.inst_vld_i ? bus.pc_i : 32'd0;
    assign dec.aluop   = d_aluop;
    assign dec.alusel  = d_alusel;
    assign dec.reg1    = op1;
    assign dec.reg2    = op2;
    assign dec.wd      = d_wd;
    assign dec.wreg    = d_wreg;
    assign dec.is_load = d_load;

    assign stall = bus.ex_is_load_i && ex_q.wreg && ex_q.wd != 5'd0 &&
                   ((re1 && rs == ex_q.wd) || (re2 && rt == ex_q.wd));

    assign bus.stall_req_o = stall;

    // ID/EX register: flush beats hold beats bubble beats load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else if (bus.flush_i) begin
            ex_q <= '0;
        end else if (!bus.hold_i) begin
            if (stall) begin
                ex_q <= '0;
            end else begin
                ex_q <= dec;
                if (inv && cnt_q != '1)
                    cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.ex_pc_o      = ex_q.pc;
    assign bus.ex_aluop_o   = ex_q.aluop;
    assign bus.ex_alusel_o  = ex_q.alusel;
    assign bus.ex_reg1_o    = ex_q.reg1;
    assign bus.ex_reg2_o    = ex_q.reg2;
    assign bus.ex_wd_o      = ex_q.wd;
    assign bus.ex_wreg_o    = ex_q.wreg;
    assign bus.ex_is_load_o = ex_q.is_load;
    assign bus.inv_cnt_o    = cnt_q;
endmodule

// File: tb/tb_id_stage_p.sv
// tb_id_stage_p: directed vectors with a queue scoreboard on ID/EX;
// a second instance with a 2-bit counter checks saturation.
module tb_id_stage_p;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_stage_p_if #(.DATA_W(32), .FWD_N(2), .CNT_W(16)) bus0 ();
    id_stage_p_if #(.DATA_W(32), .FWD_N(2), .CNT_W(2))  bus1 ();

    id_stage_p #(.DATA_W(32), .FWD_N(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    id_stage_p #(.DATA_W(32), .FWD_N(2), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    assign bus0.ex_is_load_i = bus0.ex_is_load_o;
    assign bus1.ex_is_load_i = bus1.ex_is_load_o;
    assign bus1.pc_i        = bus0.pc_i;
    assign bus1.inst_i      = bus0.inst_i;
    assign bus1.inst_vld_i  = bus0.inst_vld_i;
    assign bus1.reg1_data_i = bus0.reg1_data_i;
    assign bus1.reg2_data_i = bus0.reg2_data_i;
    assign bus1.fwd_wreg_i  = bus0.fwd_wreg_i;
    assign bus1.fwd_wd_i    = bus0.fwd_wd_i;
    assign bus1.fwd_wdata_i = bus0.fwd_wdata_i;
    assign bus1.hold_i      = bus0.hold_i;
    assign bus1.flush_i     = bus0.flush_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        ld;
        logic [15:0] inv;
        logic [1:0]  inv_s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   einv   = 0;
    int   einv_s = 0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [7:0] aluop,
                                input logic [2:0] sel, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [4:0] wd,
                                input logic wreg, input logic ld);
        exp_t e;
        e = '0;
        e.pc = pc; e.aluop = aluop; e.sel = sel; e.r1 = r1; e.r2 = r2;
        e.wd = wd; e.wreg = wreg; e.ld = ld;
        return e;
    endfunction

    function automatic exp_t got_now();
        exp_t g;
        g.pc = bus0.ex_pc_o; g.aluop = bus0.ex_aluop_o;
        g.sel = bus0.ex_alusel_o; g.r1 = bus0.ex_reg1_o;
        g.r2 = bus0.ex_reg2_o; g.wd = bus0.ex_wd_o;
        g.wreg = bus0.ex_wreg_o; g.ld = bus0.ex_is_load_o;
        g.inv = bus0.inv_cnt_o; g.inv_s = bus1.inv_cnt_o;
        return g;
    endfunction

    task automatic cmp_ex(input string n, input exp_t g, input exp_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h op=%h sel=%b r1=%h r2=%h wd=%0d wr=%b ld=%b inv=%0d invs=%0d, required pc=%h op=%h sel=%b r1=%h r2=%h wd=%0d wr=%b ld=%b inv=%0d invs=%0d",
                     n, g.pc, g.aluop, g.sel, g.r1, g.r2, g.wd, g.wreg, g.ld, g.inv, g.inv_s,
                     e.pc, e.aluop, e.sel, e.r1, e.r2, e.wd, e.wreg, e.ld, e.inv, e.inv_s);
        end
    endtask

    task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, g, e);
        end
    endtask

    // Monitor: each cycle with a pending expectation, compare ID/EX
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp_ex("ex_regs", got_now(), e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rt_w(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] it_w(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic put(input logic [31:0] pc, input logic [31:0] w,
                       input logic [31:0] d1, input logic [31:0] d2);
        bus0.pc_i = pc; bus0.inst_i = w; bus0.inst_vld_i = 1'b1;
        bus0.reg1_data_i = d1; bus0.reg2_data_i = d2;
    endtask

    task automatic fwd(input int k, input logic en, input logic [4:0] wd,
                       input logic [31:0] d);
        bus0.fwd_wreg_i[k] = en;
        bus0.fwd_wd_i[5*k +: 5] = wd;
        bus0.fwd_wdata_i[32*k +: 32] = d;
    endtask

    task automatic fwd_off();
        bus0.fwd_wreg_i = '0; bus0.fwd_wd_i = '0; bus0.fwd_wdata_i = '0;
    endtask

    // Called at a falling edge with inputs set; checks stall, queues result
    task automatic issue(input string n, input exp_t e, input logic st);
        #1;
        chk({n, "_stall"}, 32'(bus0.stall_req_o), 32'(st));
        e.inv = 16'(einv);
        e.inv_s = 2'(einv_s);
        q.push_back(e);
        @(negedge clk);
    endtask

    exp_t nop;
    exp_t e13;
    exp_t e18;
    logic [31:0] w;

    initial begin
        nop = '0;
        bus0.pc_i = '0; bus0.inst_i = '0; bus0.inst_vld_i = 1'b0;
        bus0.reg1_data_i = '0; bus0.reg2_data_i = '0;
        bus0.hold_i = 1'b0; bus0.flush_i = 1'b0;
        fwd_off();
        #2;
        cmp_ex("reset_state", got_now(), nop);
        @(negedge clk);
        rst = 1'b1;

        put(32'h100, it_w(6'h0D, 5'd0, 5'd2, 16'h8001), 32'h1234, 32'h0);
        issue("ori", mk(32'h100, 8'h25, 3'b001, 0, 32'h8001, 5'd2, 1, 0), 0);

        put(32'h104, it_w(6'h08, 5'd1, 5'd3, 16'hFFFF), 32'h77, 32'h0);
        fwd(0, 1, 5'd1, 32'd5); fwd(1, 1, 5'd1, 32'd9);
        issue("addi_fwd", mk(32'h104, 8'h20, 3'b100, 32'd5, 32'hFFFFFFFF, 5'd3, 1, 0), 0);

        fwd_off();
        put(32'h108, it_w(6'h23, 5'd1, 5'd4, 16'h0000), 32'h1000, 32'h0);
        issue("lw", mk(32'h108, 8'hE3, 3'b111, 32'h1000, 0, 5'd4, 1, 1), 0);

        put(32'h10C, rt_w(5'd4, 5'd6, 5'd5, 5'd0, 6'h25), 32'hDEAD, 32'h66);
        issue("loaduse", nop, 1);

        fwd(1, 1, 5'd4, 32'h4444);
        issue("or_after", mk(32'h10C, 8'h25, 3'b001, 32'h4444, 32'h66, 5'd5, 1, 0), 0);

        fwd_off();
        fwd(0, 1, 5'd0, 32'hAA);
        put(32'h110, rt_w(5'd0, 5'd8, 5'd7, 5'd3, 6'h00), 32'h0, 32'h88);
        #1;
        chk("sll_re1", 32'(bus0.reg1_read_o), 0);
        chk("sll_re2", 32'(bus0.reg2_read_o), 1);
        chk("sll_a2", 32'(bus0.reg2_addr_o), 8);
        issue("sll", mk(32'h110, 8'h7C, 3'b010, 32'd3, 32'h88, 5'd7, 1, 0), 0);

        put(32'h114, rt_w(5'd0, 5'd0, 5'd1, 5'd0, 6'h25), 32'h55, 32'h66);
        issue("zero_nofwd", mk(32'h114, 8'h25, 3'b001, 0, 0, 5'd1, 1, 0), 0);

        fwd(0, 1, 5'd10, 32'hA0); fwd(1, 1, 5'd11, 32'hB0);
        put(32'h118, rt_w(5'd10, 5'd11, 5'd9, 5'd0, 6'h22), 32'h1, 32'h2);
        issue("sub_fwd2", mk(32'h118, 8'h22, 3'b100, 32'hA0, 32'hB0, 5'd9, 1, 0), 0);

        fwd_off();
        put(32'h11C, it_w(6'h0F, 5'd0, 5'd12, 16'hABCD), 32'h9, 32'h0);
        issue("lui", mk(32'h11C, 8'h25, 3'b001, 0, 32'hABCD0000, 5'd12, 1, 0), 0);

        put(32'h120, rt_w(5'd0, 5'd14, 5'd13, 5'd31, 6'h03), 32'h0, 32'h80000000);
        issue("sra", mk(32'h120, 8'h03, 3'b010, 32'd31, 32'h80000000, 5'd13, 1, 0), 0);

        put(32'h124, it_w(6'h0C, 5'd16, 5'd15, 16'hF0F0), 32'h1111, 32'h0);
        issue("andi", mk(32'h124, 8'h24, 3'b001, 32'h1111, 32'hF0F0, 5'd15, 1, 0), 0);

        put(32'h128, rt_w(5'd2, 5'd3, 5'd1, 5'd0, 6'h21), 32'h1, 32'h2);
        bus0.flush_i = 1'b1; bus0.hold_i = 1'b1;
        issue("flush_hold", nop, 0);

        bus0.flush_i = 1'b0; bus0.hold_i = 1'b0;
        put(32'h12C, rt_w(5'd18, 5'd19, 5'd17, 5'd0, 6'h21), 32'h10, 32'h20);
        e13 = mk(32'h12C, 8'h21, 3'b100, 32'h10, 32'h20, 5'd17, 1, 0);
        issue("addu", e13, 0);

        bus0.hold_i = 1'b1;
        put(32'h130, it_w(6'h0E, 5'd6, 5'd5, 16'h0001), 32'h3, 32'h0);
        for (int i = 0; i < 3; i++) issue("hold", e13, 0);

        bus0.hold_i = 1'b0;
        bus0.inst_vld_i = 1'b0;
        issue("not_valid", nop, 0);

        put(32'h134, it_w(6'h23, 5'd21, 5'd20, 16'h0004), 32'h200, 32'h0);
        e18 = mk(32'h134, 8'hE3, 3'b111, 32'h200, 32'd4, 5'd20, 1, 1);
        issue("lw2", e18, 0);

        put(32'h138, rt_w(5'd20, 5'd0, 5'd22, 5'd0, 6'h26), 32'h1, 32'h0);
        bus0.hold_i = 1'b1;
        issue("hold_hazard", e18, 1);
        bus0.hold_i = 1'b0;
        issue("bubble", nop, 1);
        fwd(1, 1, 5'd20, 32'h5050);
        issue("xor_after", mk(32'h138, 8'h26, 3'b001, 32'h5050, 0, 5'd22, 1, 0), 0);

        fwd_off();
        for (int i = 0; i < 3; i++) begin
            put(32'h13C + 32'(4 * i), 32'hFC000000 | 32'(i), 32'h0, 32'h0);
            einv++; einv_s++;
            issue("invalid", mk(32'h13C + 32'(4 * i), 0, 0, 0, 0, 0, 0, 0), 0);
        end
        put(32'h148, rt_w(5'd1, 5'd2, 5'd3, 5'd5, 6'h25), 32'h0, 32'h0);
        einv++;
        issue("inv_sa", mk(32'h148, 0, 0, 0, 0, 0, 0, 0), 0);
        put(32'h14C, 32'hFFFFFFFF, 32'h0, 32'h0);
        einv++;
        issue("inv_sat", mk(32'h14C, 0, 0, 0, 0, 0, 0, 0), 0);

        put(32'h150, it_w(6'h23, 5'd2, 5'd1, 16'h0000), 32'h300, 32'h0);
        issue("lw3", mk(32'h150, 8'hE3, 3'b111, 32'h300, 0, 5'd1, 1, 1), 0);

        w = rt_w(5'd1, 5'd1, 5'd3, 5'd0, 6'h25);
        put(32'h154, w, 32'h7, 32'h7);
        #1;
        chk("pre_rst_stall", 32'(bus0.stall_req_o), 1);
        #1;
        rst = 1'b0;
        #1;
        cmp_ex("mid_rst", got_now(), nop);
        chk("mid_rst_stall", 32'(bus0.stall_req_o), 0);
        @(negedge clk);
        rst = 1'b1;
        einv = 0; einv_s = 0;
        issue("post_rst", mk(32'h154, 8'h25, 3'b001, 32'h7, 32'h7, 5'd3, 1, 0), 0);

        @(negedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
